count_bcd_display: RTL and testbench

Downstream consumer of the 8-bit up/down counter: it samples the counter value and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine. It drives a time-multiplexed 4-digit seven-segment display from the converted digits. The block sits between the counter output and the board display pins and re-converts only when the counter value has changed.

---
 rtl/count_bcd_display.sv | 238 +++++++++++++++++++++++
 tb/tb_count_bcd_display.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_bcd_display.sv
// ---------------------------------------------------------------------------
// count_bcd_display
//
// Samples an 8-bit counter value, converts it to three BCD digits with a
// sequential shift-add-3 (double-dabble) engine, and drives a time-multiplexed
// 4-digit seven-segment display from the converted digits.  A new conversion
// is started only when the sampled value differs from the last captured one
// (or once after reset).
//
// Optional feature macro: SIGNED_DISPLAY_EN
//   defined   : value is two's complement; the magnitude is converted and the
//               sign digit (an[3]) shows '-' for negative values.
//   undefined : value is unsigned 0..255; neg is tied low, sign digit blank.
//
// Parameters:
//   SCAN_DIV   clock cycles each digit stays lit (2..65535)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   value      [7:0] counter value to display
//   bcd_hund   [3:0] hundreds digit of the last conversion
//   bcd_tens   [3:0] tens digit of the last conversion
//   bcd_ones   [3:0] ones digit of the last conversion
//   neg        last conversion was negative
//   conv_done  one-cycle pulse when the BCD outputs update
//   seg        [6:0] active-high segments {g,f,e,d,c,b,a}
//   an         [3:0] one-hot digit enable; an[0] = ones, an[3] = sign
// ---------------------------------------------------------------------------
module count_bcd_display #(
    parameter int unsigned SCAN_DIV = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] value,
    output logic [3:0] bcd_hund,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       neg,
    output logic       conv_done,
    output logic [6:0] seg,
    output logic [3:0] an
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_ZERO  = 7'b0111111;

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

    // -----------------------------------------------------------------------
    // Glyph lookup for a single decimal digit
    // -----------------------------------------------------------------------
    function automatic logic [6:0] f_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b0111111;
            4'd1:    g = 7'b0000110;
            4'd2:    g = 7'b1011011;
            4'd3:    g = 7'b1001111;
            4'd4:    g = 7'b1100110;
            4'd5:    g = 7'b1101101;
            4'd6:    g = 7'b1111101;
            4'd7:    g = 7'b0000111;
            4'd8:    g = 7'b1111111;
            4'd9:    g = 7'b1101111;
            default: g = 7'b0000000;
        endcase
        return g;
    endfunction

    // -----------------------------------------------------------------------
    // Conversion engine state
    // -----------------------------------------------------------------------
    logic [1:0]  r_state;
    logic        r_first_pending;
    logic [7:0]  r_last_src;
    logic [19:0] r_shift;
    logic [2:0]  r_bit_cnt;
    logic [3:0]  r_bcd_hund;
    logic [3:0]  r_bcd_tens;
    logic [3:0]  r_bcd_ones;
    logic        r_conv_done;
    logic        r_neg;

    logic [7:0]  w_mag;
    logic        w_changed;
    logic [19:0] w_adj;
    logic [19:0] w_shift_next;

`ifdef SIGNED_DISPLAY_EN
    logic        r_src_neg;

    // Two's-complement magnitude; 8'h80 wraps to 8'h80, read as unsigned 128.
    assign w_mag = value[7] ? (~value + 8'd1) : value;
`else
    assign w_mag = value;
`endif

    assign w_changed = r_first_pending || (value != r_last_src);

    // Add-3 correction on each BCD nibble (bits 19:8) ahead of the shift.
    always_comb begin
        w_adj = r_shift;
        for (int unsigned i = 0; i < 3; i++) begin
            if (r_shift[8 + 4*i +: 4] >= 4'd5) begin
                w_adj[8 + 4*i +: 4] = r_shift[8 + 4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_shift_next = w_adj << 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_first_pending <= 1'b1;
            r_last_src      <= '0;
            r_shift         <= '0;
            r_bit_cnt       <= '0;
            r_bcd_hund      <= '0;
            r_bcd_tens      <= '0;
            r_bcd_ones      <= '0;
            r_conv_done     <= 1'b0;
            r_neg           <= 1'b0;
`ifdef SIGNED_DISPLAY_EN
            r_src_neg       <= 1'b0;
`endif
        end else begin
            r_conv_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_changed) begin
`ifdef SIGNED_DISPLAY_EN
                        r_src_neg       <= value[7];
`endif
                        r_shift         <= {12'b0, w_mag};
                        r_bit_cnt       <= '0;
                        r_last_src      <= value;
                        r_first_pending <= 1'b0;
                        r_state         <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    r_shift   <= w_shift_next;
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_state <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    r_bcd_hund  <= r_shift[19:16];
                    r_bcd_tens  <= r_shift[15:12];
                    r_bcd_ones  <= r_shift[11:8];
`ifdef SIGNED_DISPLAY_EN
                    r_neg       <= r_src_neg;
`else
                    r_neg       <= 1'b0;
`endif
                    r_conv_done <= 1'b1;
                    r_state     <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bcd_hund  = r_bcd_hund;
    assign bcd_tens  = r_bcd_tens;
    assign bcd_ones  = r_bcd_ones;
    assign conv_done = r_conv_done;
`ifdef SIGNED_DISPLAY_EN
    assign neg       = r_neg;
`else
    assign neg       = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Display scan
    // -----------------------------------------------------------------------
    logic [15:0] r_div;
    logic [1:0]  r_digit;
    logic [6:0]  r_seg;
    logic [3:0]  r_an;

    logic        w_div_tc;
    logic [1:0]  w_digit_next;
    logic [6:0]  w_seg_next;

    assign w_div_tc     = (r_div == DIV_LAST);
    assign w_digit_next = r_digit + 2'd1;

    // Glyph for the digit about to be lit, with leading-zero blanking.
    always_comb begin
        w_seg_next = SEG_BLANK;
        case (w_digit_next)
            2'd0: w_seg_next = f_glyph(r_bcd_ones);
            2'd1: w_seg_next = (r_bcd_hund == 4'd0 && r_bcd_tens == 4'd0)
                               ? SEG_BLANK : f_glyph(r_bcd_tens);
            2'd2: w_seg_next = (r_bcd_hund == 4'd0)
                               ? SEG_BLANK : f_glyph(r_bcd_hund);
            2'd3: w_seg_next = r_neg ? SEG_DASH : SEG_BLANK;
            default: w_seg_next = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div   <= '0;
            r_digit <= '0;
            r_an    <= 4'b0001;
            r_seg   <= SEG_ZERO;
        end else if (w_div_tc) begin
            r_div   <= '0;
            r_digit <= w_digit_next;
            r_an    <= 4'b0001 << w_digit_next;
            r_seg   <= w_seg_next;
        end else begin
            r_div   <= r_div + 16'd1;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule

// File: tb/tb_count_bcd_display.sv
module tb_count_bcd_display;

    localparam int SD = 4;

    logic       clk;
    logic       reset;
    logic [7:0] value;
    logic [3:0] bcd_hund;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       neg;
    logic       conv_done;
    logic [6:0] seg;
    logic [3:0] an;

    int n_vec = 0;
    int n_err = 0;

    // reference model state: what the display should currently represent
    int exp_mag = 0;
    int exp_neg = 0;

    localparam logic [6:0] GLYPH [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    count_bcd_display #(.SCAN_DIV(SD)) dut (
        .clk       (clk),
        .reset     (reset),
        .value     (value),
        .bcd_hund  (bcd_hund),
        .bcd_tens  (bcd_tens),
        .bcd_ones  (bcd_ones),
        .neg       (neg),
        .conv_done (conv_done),
        .seg       (seg),
        .an        (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int mag_of(input logic [7:0] v);
`ifdef SIGNED_DISPLAY_EN
        return v[7] ? 256 - int'(v) : int'(v);
`else
        return int'(v);
`endif
    endfunction

    function automatic int neg_of(input logic [7:0] v);
`ifdef SIGNED_DISPLAY_EN
        return v[7] ? 1 : 0;
`else
        return (v === 8'hxx) ? 1 : 0;
`endif
    endfunction

    function automatic logic [6:0] exp_glyph(input int idx);
        case (idx)
            0: return GLYPH[exp_mag % 10];
            1: return (exp_mag >= 10) ? GLYPH[(exp_mag / 10) % 10] : 7'b0000000;
            2: return (exp_mag >= 100) ? GLYPH[exp_mag / 100] : 7'b0000000;
            default: return (exp_neg != 0) ? 7'b1000000 : 7'b0000000;
        endcase
    endfunction

    // drive a new value and check latency, digits, sign and pulse width
    task automatic convert_and_check(input logic [7:0] v, input string tag);
        int lat;
        bit got;
        lat = 0;
        got = 0;
        exp_mag = mag_of(v);
        exp_neg = neg_of(v);
        value = v;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (conv_done === 1'b1) begin
                got = 1;
                lat = k;
                break;
            end
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL %s_timeout: conv_done never seen, expected within 10 cycles", tag);
        end else begin
            if (lat != 10) begin
                n_err++;
                $display("FAIL %s_latency: got %0d expected 10", tag, lat);
            end
            n_vec++;
            if (bcd_hund !== 4'(exp_mag / 100)) begin
                n_err++;
                $display("FAIL %s_hund: got %0d expected %0d", tag, bcd_hund, exp_mag / 100);
            end
            n_vec++;
            if (bcd_tens !== 4'((exp_mag / 10) % 10)) begin
                n_err++;
                $display("FAIL %s_tens: got %0d expected %0d", tag, bcd_tens, (exp_mag / 10) % 10);
            end
            n_vec++;
            if (bcd_ones !== 4'(exp_mag % 10)) begin
                n_err++;
                $display("FAIL %s_ones: got %0d expected %0d", tag, bcd_ones, exp_mag % 10);
            end
            n_vec++;
            if (neg !== 1'(exp_neg)) begin
                n_err++;
                $display("FAIL %s_neg: got %0b expected %0d", tag, neg, exp_neg);
            end
            tick();
            n_vec++;
            if (conv_done !== 1'b0) begin
                n_err++;
                $display("FAIL %s_pulse: conv_done got %0b expected 0", tag, conv_done);
            end
        end
    endtask

    // let every digit refresh, then check a full scan period
    task automatic check_display(input string tag);
        int idx;
        repeat (4 * SD) tick();
        for (int k = 0; k < 4 * SD; k++) begin
            tick();
            case (an)
                4'b0001: idx = 0;
                4'b0010: idx = 1;
                4'b0100: idx = 2;
                4'b1000: idx = 3;
                default: idx = -1;
            endcase
            n_vec++;
            if (idx < 0) begin
                n_err++;
                $display("FAIL %s_an: got %b expected one-hot", tag, an);
            end else if (seg !== exp_glyph(idx)) begin
                n_err++;
                $display("FAIL %s_seg%0d: got %b expected %b", tag, idx, seg, exp_glyph(idx));
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        reset = 1'b1;
        value = 8'd0;
        repeat (3) tick();
        n_vec++;
        if (bcd_hund !== 4'd0 || bcd_tens !== 4'd0 || bcd_ones !== 4'd0) begin
            n_err++;
            $display("FAIL reset_bcd: got %0d/%0d/%0d expected 0/0/0", bcd_hund, bcd_tens, bcd_ones);
        end
        n_vec++;
        if (neg !== 1'b0 || conv_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: got neg=%b done=%b expected 0/0", neg, conv_done);
        end
        n_vec++;
        if (an !== 4'b0001 || seg !== 7'b0111111) begin
            n_err++;
            $display("FAIL reset_disp: got an=%b seg=%b expected 0001/0111111", an, seg);
        end
        exp_mag = 0;
        exp_neg = 0;
        reset = 1'b0;
        for (int k = 1; k <= 8 * SD + 4; k++) begin
            tick();
            n_vec++;
            if (conv_done !== ((k == 10) ? 1'b1 : 1'b0)) begin
                n_err++;
                $display("FAIL first_conv_done@%0d: got %b expected %b", k, conv_done, (k == 10));
            end
            exp_an = 4'b0001 << ((k / SD) % 4);
            exp_seg = (((k / SD) % 4) == 0) ? 7'b0111111 : 7'b0000000;
            n_vec++;
            if (an !== exp_an || seg !== exp_seg) begin
                n_err++;
                $display("FAIL scan_walk@%0d: got an=%b seg=%b expected %b/%b", k, an, seg, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_directed();
`ifdef SIGNED_DISPLAY_EN
        convert_and_check(8'hFF, "neg_one");
        check_display("neg_one");
        convert_and_check(8'h80, "neg_128");
        check_display("neg_128");
        convert_and_check(8'd127, "pos_127");
        check_display("pos_127");
`else
        convert_and_check(8'd255, "u255");
        check_display("u255");
`endif
        convert_and_check(8'd7, "v7");
        check_display("v7");
        convert_and_check(8'd105, "v105");
        check_display("v105");
        convert_and_check(8'd0, "v0");
        check_display("v0");
    endtask

    task automatic test_hold();
        for (int k = 0; k < 30; k++) begin
            tick();
            n_vec++;
            if (conv_done !== 1'b0) begin
                n_err++;
                $display("FAIL hold_no_pulse@%0d: got %b expected 0", k, conv_done);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] v;
        for (int n = 0; n < 16; n++) begin
            v = 8'($urandom_range(255, 0));
            if (v == value) v = v ^ 8'h01;
            convert_and_check(v, "rand");
            check_display("rand");
        end
    endtask

    // value changes while the engine is busy: only the newest value is taken
    task automatic test_back_to_back();
        convert_and_check(8'd200, "pre_b2b");
        value = 8'd10;
        for (int k = 1; k <= 22; k++) begin
            tick();
            if (k == 1) value = 8'd11;
            if (k == 2) value = 8'd12;
            n_vec++;
            if (conv_done !== ((k == 10 || k == 20) ? 1'b1 : 1'b0)) begin
                n_err++;
                $display("FAIL b2b_done@%0d: got %b expected %b", k, conv_done, (k == 10 || k == 20));
            end
            if (k == 10 || k == 20) begin
                n_vec++;
                if ({bcd_hund, bcd_tens, bcd_ones} !== ((k == 10) ? 12'h010 : 12'h012)) begin
                    n_err++;
                    $display("FAIL b2b_value@%0d: got %h expected %h", k,
                             {bcd_hund, bcd_tens, bcd_ones}, (k == 10) ? 12'h010 : 12'h012);
                end
            end
        end
        // change landing in the LOAD cycle
        value = 8'd33;
        for (int k = 1; k <= 22; k++) begin
            tick();
            if (k == 9) value = 8'd44;
            n_vec++;
            if (conv_done !== ((k == 10 || k == 20) ? 1'b1 : 1'b0)) begin
                n_err++;
                $display("FAIL loadchg_done@%0d: got %b expected %b", k, conv_done, (k == 10 || k == 20));
            end
            if (k == 10 || k == 20) begin
                n_vec++;
                if ({bcd_hund, bcd_tens, bcd_ones} !== ((k == 10) ? 12'h033 : 12'h044)) begin
                    n_err++;
                    $display("FAIL loadchg_value@%0d: got %h expected %h", k,
                             {bcd_hund, bcd_tens, bcd_ones}, (k == 10) ? 12'h033 : 12'h044);
                end
            end
        end
        exp_mag = 44;
        exp_neg = 0;
        check_display("after_loadchg");
    endtask

    task automatic test_reset_mid();
        convert_and_check(8'd200, "pre_rst");
        value = 8'd99;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_vec++;
            if (conv_done !== 1'b0) begin
                n_err++;
                $display("FAIL rstmid_early@%0d: got %b expected 0", k, conv_done);
            end
        end
        reset = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_vec++;
            if ({bcd_hund, bcd_tens, bcd_ones} !== 12'h000 || conv_done !== 1'b0 || neg !== 1'b0) begin
                n_err++;
                $display("FAIL rstmid_out@%0d: got bcd=%h done=%b neg=%b expected 000/0/0", k,
                         {bcd_hund, bcd_tens, bcd_ones}, conv_done, neg);
            end
            n_vec++;
            if (an !== 4'b0001 || seg !== 7'b0111111) begin
                n_err++;
                $display("FAIL rstmid_disp@%0d: got an=%b seg=%b expected 0001/0111111", k, an, seg);
            end
        end
        reset = 1'b0;
        // after reset the same value must still be converted (first_pending)
        convert_and_check(8'd99, "post_rst");
        check_display("post_rst");
    endtask

    initial begin
        reset = 1'b1;
        value = 8'd0;
        test_reset();
        test_directed();
        test_hold();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
